phys_reg_free_list: RTL

Circular FIFO of free physical register numbers feeding the rename/dispatch stage. It is the consumer end of the reorder_buffer's retire and rollback outputs:
- Retired PR_old values return to the list.
- On recovery, flushed PR_new values are un-allocated back at the head.
- Dispatch pops PR_new_DP from the head.

---
 rtl/ooo_pkg.sv | 24 ++
 rtl/phys_reg_free_list.sv | 94 +++++++++
 2 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core sizing: physical/architectural register counts,
// ROB index width, free-list geometry and pointer-wrap helpers.
package ooo_pkg;

   localparam int NUM_PR   = 64;
   localparam int NUM_AR   = 32;
   localparam int PR_W     = 6;
   localparam int ROB_W    = 4;

   // Free list holds every physical register not mapped at reset.
   localparam int FL_DEPTH = NUM_PR - NUM_AR;
   localparam int FL_PTR_W = $clog2(FL_DEPTH);

   // Advance a free-list pointer by one slot, wrapping modulo FL_DEPTH.
   function automatic logic [FL_PTR_W-1:0] fl_ptr_inc(input logic [FL_PTR_W-1:0] p);
      return (p == FL_PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Step a free-list pointer back one slot, wrapping modulo FL_DEPTH.
   function automatic logic [FL_PTR_W-1:0] fl_ptr_dec(input logic [FL_PTR_W-1:0] p);
      return (p == '0) ? FL_PTR_W'(FL_DEPTH - 1) : p - 1'b1;
   endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register numbers. Dispatch pops from the
// head (show-ahead), retirement pushes freed PRs at the tail, and ROB
// rollback un-pops flushed PRs back in front of the head.
module phys_reg_free_list
   import ooo_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            isDispatch,
   input  logic            RegDest,
   input  logic            hazard_stall,
   output logic [PR_W-1:0] PR_new_DP,
   output logic            empty,
   input  logic            retire_reg,
   input  logic            RegDest_retire,
   input  logic [PR_W-1:0] PR_old_RT,
   input  logic            recover,
   input  logic            RegDest_out,
   input  logic [PR_W-1:0] PR_new_flush,
   output logic [PR_W-1:0] free_count,
   output logic            overflow_err
);

   logic [PR_W-1:0]     r_mem [FL_DEPTH];
   logic [FL_PTR_W-1:0] r_head;
   logic [FL_PTR_W-1:0] r_tail;
   logic [PR_W-1:0]     r_count;
   logic                r_overflow;

   logic                w_empty;
   logic                w_alloc;
   logic                w_ret_push;
   logic                w_rb_push;
   logic                w_ret_ok;
   logic                w_rb_ok;
   logic [PR_W-1:0]     w_count_after_ret;
   logic [FL_PTR_W-1:0] w_head_m1;

   assign w_empty    = (r_count == '0);
   assign w_head_m1  = fl_ptr_dec(r_head);

   // Rollback squashes the dispatch in the same cycle, so it also blocks alloc.
   assign w_alloc    = isDispatch & RegDest & ~hazard_stall & ~recover & ~w_empty;
   assign w_ret_push = retire_reg & RegDest_retire;
   assign w_rb_push  = recover & RegDest_out;

   // Retire push wins the last free slot; the rollback push only fits if
   // there is still room after the retire push has been counted.
   assign w_ret_ok          = w_ret_push & (r_count != PR_W'(FL_DEPTH));
   assign w_count_after_ret = r_count + PR_W'(w_ret_ok);
   assign w_rb_ok           = w_rb_push & (w_count_after_ret != PR_W'(FL_DEPTH));

   // Outputs come only from registered state: no push input reaches them.
   assign PR_new_DP    = r_mem[r_head];
   assign empty        = w_empty;
   assign free_count   = r_count;
   assign overflow_err = r_overflow;

   // Storage: reset loads the unmapped PRs in order, then pushes write either end.
   // NOTE: this array is reset on purpose because its reset contents are the
   // initial free list; a plain data RAM would be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            r_mem[i] <= PR_W'(NUM_AR + i);
         end
      end else begin
         // Tail and head-1 coincide only when one slot is free, and then the
         // rollback push is dropped, so the two writes never collide.
         if (w_ret_ok) r_mem[r_tail]    <= PR_old_RT;
         if (w_rb_ok)  r_mem[w_head_m1] <= PR_new_flush;
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   // NOTE: all state updates use non-blocking assignment so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= PR_W'(FL_DEPTH);
         r_overflow <= 1'b0;
      end else begin
         // alloc and rollback are mutually exclusive (both depend on recover).
         if (w_alloc)      r_head <= fl_ptr_inc(r_head);
         else if (w_rb_ok) r_head <= w_head_m1;
         if (w_ret_ok)     r_tail <= fl_ptr_inc(r_tail);
         r_count <= w_count_after_ret + PR_W'(w_rb_ok) - PR_W'(w_alloc);
         if ((w_ret_push & ~w_ret_ok) | (w_rb_push & ~w_rb_ok)) r_overflow <= 1'b1;
      end
   end

endmodule
